oq_stats_engine: RTL and testbench

//  Per-queue statistics engine for the BRAM output-queue subsystem, for any NUM_QUEUES.

---
 rtl/oq_stats_engine.sv | 159 +++++++++++++++
 tb/tb_oq_stats_engine.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/oq_stats_engine.sv
// Per-queue output-queue statistics: cumulative, occupancy and peak counters,
// with saturating/wrapping arithmetic, clear-on-read and a 1-cycle read port.

module oq_stats_lane #(
    parameter int CNTR_WIDTH  = 32,
    parameter int BYTES_WIDTH = 16,
    parameter int SATURATE    = 1
) (
    input  logic                         axi_aclk,
    input  logic                         axi_reset,
    input  logic                         st,
    input  logic [BYTES_WIDTH-1:0]       st_bytes,
    input  logic                         rm,
    input  logic [BYTES_WIDTH-1:0]       rm_bytes,
    input  logic                         dp,
    input  logic [BYTES_WIDTH-1:0]       dp_bytes,
    input  logic                         rst_cntrs,
    input  logic [7:0]                   clr,
    output logic [7:0][CNTR_WIDTH-1:0]   cntrs
);
    // Sum width covers the wider of counter/byte input plus a carry bit
    localparam int SW  = ((CNTR_WIDTH > BYTES_WIDTH) ? CNTR_WIDTH : BYTES_WIDTH) + 1;
    localparam int SW1 = SW + 1;
    localparam int LW  = SW + 1;

    logic [5:0][CNTR_WIDTH-1:0] cum, cum_n;
    logic [CNTR_WIDTH-1:0]      pkt, pkt_n, live, live_n, peak, peak_n, peak_b;
    logic [5:0]                 ev;
    logic [5:0][SW-1:0]         inc;
    logic [LW-1:0]              up, dn, diff;

    function automatic logic [CNTR_WIDTH-1:0] sat_add(input logic [CNTR_WIDTH-1:0] a,
                                                      input logic [SW-1:0] b);
        logic [SW:0] s;
        s = SW1'(a) + SW1'(b);
        if (SATURATE != 0 && s[SW:CNTR_WIDTH] != '0)
            return '1;
        return s[CNTR_WIDTH-1:0];
    endfunction

    always_comb begin
        ev     = {dp, dp, rm, rm, st, st};
        inc[0] = SW'(1);
        inc[1] = SW'(st_bytes);
        inc[2] = SW'(1);
        inc[3] = SW'(rm_bytes);
        inc[4] = SW'(1);
        inc[5] = SW'(dp_bytes);
        for (int i = 0; i < 6; i++) begin
            cum_n[i] = clr[i] ? '0 : cum[i];
            if (ev[i])
                cum_n[i] = sat_add(cum_n[i], inc[i]);
        end

        pkt_n = pkt;
        if (st && !rm)
            pkt_n = sat_add(pkt, SW'(1));
        else if (rm && !st && pkt != '0)
            pkt_n = pkt - CNTR_WIDTH'(1);

        // Live bytes clamp at zero on underflow instead of wrapping
        up   = LW'(live) + (st ? LW'(st_bytes) : '0);
        dn   = rm ? LW'(rm_bytes) : '0;
        diff = up - dn;
        if (up < dn)
            live_n = '0;
        else if (SATURATE != 0 && diff[LW-1:CNTR_WIDTH] != '0)
            live_n = '1;
        else
            live_n = diff[CNTR_WIDTH-1:0];

        peak_b = clr[7] ? '0 : peak;
        peak_n = (live_n > peak_b) ? live_n : peak_b;
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            cum  <= '0;
            pkt  <= '0;
            live <= '0;
            peak <= '0;
        end else begin
            cum  <= rst_cntrs ? '0 : cum_n;
            peak <= rst_cntrs ? '0 : peak_n;
            pkt  <= pkt_n;
            live <= live_n;
        end
    end

    assign cntrs = {peak, pkt, cum};
endmodule

module oq_stats_engine #(
    parameter int NUM_QUEUES    = 8,
    parameter int CNTR_WIDTH    = 32,
    parameter int BYTES_WIDTH   = 16,
    parameter int SATURATE      = 1,
    parameter int CLEAR_ON_READ = 0,
    localparam int ADDR_WIDTH   = $clog2(NUM_QUEUES*8)
) (
    input  logic                              axi_aclk,
    input  logic                              axi_reset,
    input  logic [NUM_QUEUES-1:0]             pkt_stored,
    input  logic [BYTES_WIDTH-1:0]            bytes_stored,
    input  logic [NUM_QUEUES-1:0]             pkt_removed,
    input  logic [NUM_QUEUES*BYTES_WIDTH-1:0] bytes_removed,
    input  logic [NUM_QUEUES-1:0]             pkt_dropped,
    input  logic [BYTES_WIDTH-1:0]            bytes_dropped,
    input  logic                              rst_cntrs,
    input  logic                              rd_en,
    input  logic [ADDR_WIDTH-1:0]             rd_addr,
    output logic                              rd_valid,
    output logic [CNTR_WIDTH-1:0]             rd_data
);
    localparam int NC = NUM_QUEUES * 8;

    logic [NUM_QUEUES-1:0][7:0][CNTR_WIDTH-1:0] cntrs;
    logic [NC-1:0][CNTR_WIDTH-1:0]              flat;
    logic [NUM_QUEUES-1:0][7:0]                 clr;
    logic                                       addr_ok;

    assign flat    = cntrs;
    assign addr_ok = 32'(rd_addr) < NC;

    for (genvar q = 0; q < NUM_QUEUES; q++) begin : g_lane
        // Occupancy (id 6) is never cleared by a read
        assign clr[q] = (CLEAR_ON_READ != 0 && rd_en && (32'(rd_addr) >> 3) == q)
                        ? ((8'b1 << rd_addr[2:0]) & 8'hBF) : 8'h00;

        oq_stats_lane #(
            .CNTR_WIDTH (CNTR_WIDTH),
            .BYTES_WIDTH(BYTES_WIDTH),
            .SATURATE   (SATURATE)
        ) u_lane (
            .axi_aclk (axi_aclk),
            .axi_reset(axi_reset),
            .st       (pkt_stored[q]),
            .st_bytes (bytes_stored),
            .rm       (pkt_removed[q]),
            .rm_bytes (bytes_removed[q*BYTES_WIDTH +: BYTES_WIDTH]),
            .dp       (pkt_dropped[q]),
            .dp_bytes (bytes_dropped),
            .rst_cntrs(rst_cntrs),
            .clr      (clr[q]),
            .cntrs    (cntrs[q])
        );
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en)
                rd_data <= addr_ok ? flat[rd_addr] : '0;
        end
    end
endmodule

// File: tb/tb_oq_stats_engine.sv
// Scoreboard bench for oq_stats_engine: a main 32-bit instance plus 8-bit
// saturating/wrapping instances and a clear-on-read instance on shared events.

module tb_oq_stats_engine;
    localparam int NQ = 6;
    localparam int BW = 16;
    localparam int AW = $clog2(NQ*8);

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    logic               axi_aclk = 1'b0;
    logic               axi_reset = 1'b1;
    logic [NQ-1:0]      pkt_stored = '0, pkt_removed = '0, pkt_dropped = '0;
    logic [BW-1:0]      bytes_stored = '0, bytes_dropped = '0;
    logic [NQ*BW-1:0]   bytes_removed = '0;
    logic               rst_cntrs = 1'b0;
    logic               rd_en_m = 1'b0, rd_en_a = 1'b0, rd_en_c = 1'b0;
    logic [AW-1:0]      rd_addr = '0;
    logic               rdv_m, rdv_s, rdv_w, rdv_c, en_d;
    logic [31:0]        rdd_m, rdd_c;
    logic [7:0]         rdd_s, rdd_w;

    exp_t q_m[$], q_s[$], q_w[$], q_c[$];
    int n_checks = 0;
    int n_errors = 0;

    always #5 axi_aclk = ~axi_aclk;

    oq_stats_engine #(.NUM_QUEUES(NQ)) u_main (
        .axi_aclk(axi_aclk), .axi_reset(axi_reset),
        .pkt_stored(pkt_stored), .bytes_stored(bytes_stored),
        .pkt_removed(pkt_removed), .bytes_removed(bytes_removed),
        .pkt_dropped(pkt_dropped), .bytes_dropped(bytes_dropped),
        .rst_cntrs(rst_cntrs), .rd_en(rd_en_m), .rd_addr(rd_addr),
        .rd_valid(rdv_m), .rd_data(rdd_m));

    oq_stats_engine #(.NUM_QUEUES(NQ), .CNTR_WIDTH(8), .SATURATE(1)) u_sat8 (
        .axi_aclk(axi_aclk), .axi_reset(axi_reset),
        .pkt_stored(pkt_stored), .bytes_stored(bytes_stored),
        .pkt_removed(pkt_removed), .bytes_removed(bytes_removed),
        .pkt_dropped(pkt_dropped), .bytes_dropped(bytes_dropped),
        .rst_cntrs(rst_cntrs), .rd_en(rd_en_a), .rd_addr(rd_addr),
        .rd_valid(rdv_s), .rd_data(rdd_s));

    oq_stats_engine #(.NUM_QUEUES(NQ), .CNTR_WIDTH(8), .SATURATE(0)) u_wrap8 (
        .axi_aclk(axi_aclk), .axi_reset(axi_reset),
        .pkt_stored(pkt_stored), .bytes_stored(bytes_stored),
        .pkt_removed(pkt_removed), .bytes_removed(bytes_removed),
        .pkt_dropped(pkt_dropped), .bytes_dropped(bytes_dropped),
        .rst_cntrs(rst_cntrs), .rd_en(rd_en_a), .rd_addr(rd_addr),
        .rd_valid(rdv_w), .rd_data(rdd_w));

    oq_stats_engine #(.NUM_QUEUES(NQ), .CLEAR_ON_READ(1)) u_cor (
        .axi_aclk(axi_aclk), .axi_reset(axi_reset),
        .pkt_stored(pkt_stored), .bytes_stored(bytes_stored),
        .pkt_removed(pkt_removed), .bytes_removed(bytes_removed),
        .pkt_dropped(pkt_dropped), .bytes_dropped(bytes_dropped),
        .rst_cntrs(rst_cntrs), .rd_en(rd_en_c), .rd_addr(rd_addr),
        .rd_valid(rdv_c), .rd_data(rdd_c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge axi_aclk);
        #1;
    endtask

    task automatic rd_m(input int a, input logic [31:0] e, input string t);
        rd_addr = AW'(a);
        rd_en_m = 1'b1;
        q_m.push_back('{t, e});
        tick();
        rd_en_m = 1'b0;
    endtask

    task automatic rd_a(input int a, input logic [31:0] es, input logic [31:0] ew, input string t);
        rd_addr = AW'(a);
        rd_en_a = 1'b1;
        q_s.push_back('{{"sat8_", t}, es});
        q_w.push_back('{{"wrap8_", t}, ew});
        tick();
        rd_en_a = 1'b0;
    endtask

    task automatic rd_c(input int a, input logic [31:0] e, input string t);
        rd_addr = AW'(a);
        rd_en_c = 1'b1;
        q_c.push_back('{t, e});
        tick();
        rd_en_c = 1'b0;
    endtask

    // One-cycle event: store/remove/drop masks with byte counts
    task automatic ev(input logic [NQ-1:0] sm, input int sb, input logic [NQ-1:0] rm,
                      input int rb, input logic [NQ-1:0] dm, input int db);
        pkt_stored   = sm;
        bytes_stored = BW'(sb);
        pkt_removed  = rm;
        for (int q = 0; q < NQ; q++)
            bytes_removed[q*BW +: BW] = BW'(rb);
        pkt_dropped   = dm;
        bytes_dropped = BW'(db);
        tick();
        pkt_stored  = '0;
        pkt_removed = '0;
        pkt_dropped = '0;
    endtask

    always @(posedge axi_aclk)
        en_d <= axi_reset ? 1'b0 : rd_en_m;

    always @(negedge axi_aclk) begin
        exp_t e;
        if (!axi_reset) begin
            if (en_d || rdv_m) chk("rd_valid_timing", 32'(rdv_m), 32'(en_d));
            if (rdv_m) begin
                if (q_m.size() == 0) chk("unexpected_main", 32'(rdv_m), 32'd0);
                else begin e = q_m.pop_front(); chk(e.tag, rdd_m, e.exp); end
            end
            if (rdv_s) begin
                if (q_s.size() == 0) chk("unexpected_sat8", 32'(rdv_s), 32'd0);
                else begin e = q_s.pop_front(); chk(e.tag, 32'(rdd_s), e.exp); end
            end
            if (rdv_w) begin
                if (q_w.size() == 0) chk("unexpected_wrap8", 32'(rdv_w), 32'd0);
                else begin e = q_w.pop_front(); chk(e.tag, 32'(rdd_w), e.exp); end
            end
            if (rdv_c) begin
                if (q_c.size() == 0) chk("unexpected_cor", 32'(rdv_c), 32'd0);
                else begin e = q_c.pop_front(); chk(e.tag, rdd_c, e.exp); end
            end
        end
    end

    initial begin
        // T1: reset state
        tick(); tick();
        chk("reset_rd_valid", 32'(rdv_m), 32'd0);
        chk("reset_rd_data", rdd_m, 32'd0);
        axi_reset = 1'b0;
        for (int a = 0; a < NQ*8; a++)
            rd_m(a, 32'd0, $sformatf("reset_q%0d_id%0d", a / 8, a % 8));
        rd_a(1, 0, 0, "reset_q0_id1");
        rd_c(0, 0, "cor_reset_q0_id0");

        // T2: counting on q2, then one removal
        ev(6'b000100, 64, '0, 0, '0, 0);
        ev(6'b000100, 128, '0, 0, '0, 0);
        ev(6'b000100, 1500, '0, 0, '0, 0);
        rd_m(17, 1692, "q2_bytes_stored");
        rd_m(16, 3, "q2_pkt_stored");
        ev('0, 0, 6'b000100, 64, '0, 0);
        rd_m(22, 2, "q2_pkt_in_queue");
        rd_m(23, 1692, "q2_peak");
        rd_m(18, 1, "q2_pkt_removed");
        rd_m(19, 64, "q2_bytes_removed");
        ev('0, 0, '0, 0, 6'b010000, 77);
        rd_m(36, 1, "q4_pkt_dropped");
        rd_m(37, 77, "q4_bytes_dropped");
        rd_m(38, 0, "q4_drop_no_occupancy");

        // T3: 8-bit saturate vs wrap, 3 x 100 B on q0
        for (int i = 0; i < 3; i++) ev(6'b000001, 100, '0, 0, '0, 0);
        rd_a(1, 255, 44, "q0_bytes_stored");
        rd_a(0, 3, 3, "q0_pkt_stored");
        rd_a(7, 255, 200, "q0_peak");
        rd_m(1, 300, "q0_bytes_stored_32");

        // T4: clear-on-read racing a store
        ev(6'b000001, 10, '0, 0, '0, 0);
        ev(6'b000001, 10, '0, 0, '0, 0);
        pkt_stored   = 6'b000001;
        bytes_stored = BW'(10);
        rd_addr      = '0;
        rd_en_c      = 1'b1;
        q_c.push_back('{"cor_read_at_5", 32'd5});
        tick();
        rd_en_c    = 1'b0;
        pkt_stored = '0;
        rd_c(0, 1, "cor_after_race");
        rd_c(0, 0, "cor_cleared");
        rd_m(0, 6, "q0_pkt_stored_no_cor");
        rd_m(1, 330, "q0_bytes_stored_no_cor");

        // T5: underflow on empty q1, then rst_cntrs racing a q1 store
        ev('0, 0, 6'b000010, 40, '0, 0);
        rd_m(14, 0, "q1_underflow_pkt");
        rd_m(10, 1, "q1_pkt_removed");
        rd_m(11, 40, "q1_bytes_removed");
        rst_cntrs = 1'b1;
        ev(6'b000010, 20, '0, 0, '0, 0);
        rst_cntrs = 1'b0;
        rd_m(8, 0, "q1_rst_lost_store");
        rd_m(9, 0, "q1_rst_bytes");
        rd_m(14, 1, "q1_occ_kept");
        rd_m(10, 0, "q1_rst_removed");
        rd_m(16, 0, "q2_rst_pkt_stored");
        ev(6'b000010, 5, '0, 0, '0, 0);
        rd_m(15, 25, "q1_peak_clamped_live");
        rd_m(9, 5, "q1_bytes_after_rst");
        tick();
        chk("hold_rd_valid", 32'(rdv_m), 32'd0);
        chk("hold_rd_data", rdd_m, 32'd5);

        // T6: every queue stores and removes together, then out-of-range read
        ev('1, 10, '1, 10, '0, 0);
        rd_m(6, 6, "q0_occ_concurrent");
        rd_m(14, 2, "q1_occ_concurrent");
        rd_m(22, 2, "q2_occ_concurrent");
        rd_m(30, 0, "q3_occ_concurrent");
        rd_m(38, 0, "q4_occ_concurrent");
        rd_m(46, 0, "q5_occ_concurrent");
        rd_m(15, 25, "q1_peak_concurrent");
        rd_m(0, 1, "q0_pkt_stored_concurrent");
        rd_m(2, 1, "q0_pkt_removed_concurrent");
        rd_m(47, 0, "q5_peak_concurrent");
        rd_m(NQ*8, 0, "out_of_range");
        rd_m((1 << AW) - 1, 0, "out_of_range_top");

        for (int i = 0; i < 4; i++) tick();
        chk("scoreboard_drained", 32'(q_m.size() + q_s.size() + q_w.size() + q_c.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
